// File: rtl/hack_sequencer.sv
// Fetch/execute sequencer for the Hack CPU: fetches each instruction over a
// ROM req/ack handshake, decodes the jump condition and steps the PC once per instruction.
module hack_sequencer (
  input  logic        clk,
  input  logic        reset,
  output logic        rom_req,
  input  logic        rom_ack,
  input  logic [15:0] rom_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        zr,
  input  logic        ng,
  input  logic        mem_busy,
  output logic        pc_load,
  output logic        pc_inc,
  input  logic        halt_req,
  output logic        halted,
  output logic [15:0] instr_count
);

  localparam int unsigned WORD_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT_MEM,
    S_HALT
  } state_t;

  state_t state;
  state_t state_next;
  logic   jump;
  logic   mem_write;

  // State register; status strobes are registered from the next state so they
  // line up with the state they describe and clear asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      instr       <= '0;
      instr_count <= '0;
      rom_req     <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_next;
      rom_req     <= (state_next == S_FETCH);
      instr_valid <= (state_next == S_EXEC);
      halted      <= (state_next == S_HALT);
      if ((state == S_FETCH) && rom_ack) begin
        instr <= rom_data;
      end
      if (state == S_EXEC) begin
        instr_count <= instr_count + WORD_W'(1);
      end
    end
  end

  // Next-state and PC strobe decode; the PC strobes stay combinational so the
  // jump follows the ALU flags of the instruction being executed.
  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    jump       = instr[15] & ((instr[2] & ng) | (instr[1] & zr) | (instr[0] & ~ng & ~zr));
    mem_write  = instr[15] & instr[3];

    case (state)
      S_IDLE: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        if (rom_ack) begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        pc_load = jump;
        pc_inc  = ~jump;
        if (mem_write && mem_busy) begin
          state_next = S_WAIT_MEM;
        end else if (halt_req) begin
          state_next = S_HALT;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_WAIT_MEM: begin
        if (!mem_busy) begin
          state_next = halt_req ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        if (!halt_req) begin
          state_next = S_FETCH;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hack_sequencer.sv
// Self-checking bench for hack_sequencer: issued instructions are queued with
// their expected jump outcome and checked when the sequencer executes them.
module tb_hack_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        rom_req;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        zr;
  logic        ng;
  logic        mem_busy;
  logic        pc_load;
  logic        pc_inc;
  logic        halt_req;
  logic        halted;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_instr_q[$];
  logic        exp_jump_q[$];

  hack_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .rom_req     (rom_req),
    .rom_ack     (rom_ack),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .zr          (zr),
    .ng          (ng),
    .mem_busy    (mem_busy),
    .pc_load     (pc_load),
    .pc_inc      (pc_inc),
    .halt_req    (halt_req),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Advance to just after the next falling edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) until the sequencer requests a fetch.
  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rom_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  // Present a word with ack and queue what its execution must look like.
  task automatic issue(input logic [15:0] w, input logic j);
    rom_data = w;
    rom_ack  = 1'b1;
    exp_instr_q.push_back(w);
    exp_jump_q.push_back(j);
  endtask

  task automatic test_reset();
    reset = 1'b1; rom_ack = 1'b0; rom_data = 16'h0000; zr = 1'b0; ng = 1'b0;
    mem_busy = 1'b0; halt_req = 1'b0;
    #2;
    n_checks++;
    if ({rom_req, instr_valid, pc_load, pc_inc, halted} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 00000", {rom_req, instr_valid, pc_load, pc_inc, halted});
    end
    n_checks++;
    if (instr !== 16'h0000) begin
      n_fail++; $display("FAIL reset_instr: got %h want 0000", instr);
    end
    n_checks++;
    if (instr_count !== 16'h0000) begin
      n_fail++; $display("FAIL reset_count: got %h want 0000", instr_count);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (rom_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_rom_req: got %b want 0", rom_req);
    end
  endtask

  // Two instructions with ack tied high: FETCH/EXEC alternate every cycle.
  task automatic test_basic();
    logic [15:0] prog [2];
    logic [15:0] ew;
    logic        ej;
    prog[0] = 16'h0005;
    prog[1] = 16'hEC10;
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_checks++;
      if ({rom_req, instr_valid} !== 2'b10) begin
        n_fail++; $display("FAIL basic_fetch%0d: req/valid got %b want 10", k, {rom_req, instr_valid});
      end
      issue(prog[k], 1'b0);
      cyc();
      ew = exp_instr_q.pop_front();
      ej = exp_jump_q.pop_front();
      n_checks++;
      if ({rom_req, instr_valid, instr, pc_load, pc_inc} !== {1'b0, 1'b1, ew, ej, ~ej}) begin
        n_fail++;
        $display("FAIL basic_exec%0d: req/valid/instr/load/inc got %b/%b/%h/%b/%b want 0/1/%h/%b/%b",
                 k, rom_req, instr_valid, instr, pc_load, pc_inc, ew, ej, ~ej);
      end
    end
    cyc();
    rom_ack = 1'b0;
    n_checks++;
    if (instr_count !== 16'd2) begin
      n_fail++; $display("FAIL basic_count: got %0d want 2", instr_count);
    end
  endtask

  task automatic test_jump_decode();
    logic [15:0] words [10] = '{16'hE307, 16'hE307, 16'hE302, 16'hE302, 16'hE301,
                                16'hE301, 16'hE304, 16'h0007, 16'h0007, 16'hE300};
    logic        zrs   [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        ngs   [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        jumps [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] ew;
    logic        ej;
    bit          ok;
    for (int k = 0; k < 10; k++) begin
      wait_fetch(ok);
      n_checks++;
      if (!ok) begin
        n_fail++; $display("FAIL jump_fetch_timeout%0d: rom_req got %b want 1", k, rom_req);
      end
      issue(words[k], jumps[k]);
      cyc();
      rom_ack = 1'b0;
      zr = zrs[k];
      ng = ngs[k];
      #1;
      ew = exp_instr_q.pop_front();
      ej = exp_jump_q.pop_front();
      n_checks++;
      if ({instr_valid, instr, pc_load, pc_inc} !== {1'b1, ew, ej, ~ej}) begin
        n_fail++;
        $display("FAIL jump_%h_zr%b_ng%b: valid/instr/load/inc got %b/%h/%b/%b want 1/%h/%b/%b",
                 words[k], zrs[k], ngs[k], instr_valid, instr, pc_load, pc_inc, ew, ej, ~ej);
      end
      cyc();
      zr = 1'b0;
      ng = 1'b0;
    end
  endtask

  task automatic test_rom_latency();
    logic [15:0] prev;
    logic [15:0] ew;
    logic        ej;
    bit          ok;
    wait_fetch(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL lat_fetch_timeout: rom_req got %b want 1", rom_req);
    end
    prev = instr;
    rom_ack = 1'b0;
    rom_data = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({rom_req, instr_valid, instr} !== {1'b1, 1'b0, prev}) begin
        n_fail++;
        $display("FAIL lat_wait%0d: req/valid/instr got %b/%b/%h want 1/0/%h", i, rom_req, instr_valid, instr, prev);
      end
      if (i == 3) issue(16'h1234, 1'b0);
      cyc();
    end
    rom_ack = 1'b0;
    ew = exp_instr_q.pop_front();
    ej = exp_jump_q.pop_front();
    n_checks++;
    if ({instr_valid, instr, pc_load, pc_inc} !== {1'b1, ew, ej, ~ej}) begin
      n_fail++;
      $display("FAIL lat_exec: valid/instr/load/inc got %b/%h/%b/%b want 1/%h/%b/%b",
               instr_valid, instr, pc_load, pc_inc, ew, ej, ~ej);
    end
    cyc();
    n_checks++;
    if ({instr_valid, instr} !== {1'b0, 16'h1234}) begin
      n_fail++; $display("FAIL lat_single_exec: valid/instr got %b/%h want 0/1234", instr_valid, instr);
    end
  endtask

  task automatic test_mem_stall();
    logic [15:0] ew;
    logic        ej;
    bit          ok;
    wait_fetch(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL stall_fetch_timeout: rom_req got %b want 1", rom_req);
    end
    issue(16'hE308, 1'b0);
    cyc();
    rom_ack = 1'b0;
    mem_busy = 1'b1;
    #1;
    ew = exp_instr_q.pop_front();
    ej = exp_jump_q.pop_front();
    n_checks++;
    if ({instr_valid, instr, pc_load, pc_inc} !== {1'b1, ew, ej, ~ej}) begin
      n_fail++;
      $display("FAIL stall_exec: valid/instr/load/inc got %b/%h/%b/%b want 1/%h/%b/%b",
               instr_valid, instr, pc_load, pc_inc, ew, ej, ~ej);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_checks++;
      if ({rom_req, instr_valid, pc_load, pc_inc, halted} !== 5'b0) begin
        n_fail++;
        $display("FAIL stall_wait%0d: req/valid/load/inc/halted got %b want 00000",
                 i, {rom_req, instr_valid, pc_load, pc_inc, halted});
      end
      if (i == 1) mem_busy = 1'b0;
    end
    cyc();
    n_checks++;
    if (rom_req !== 1'b1) begin
      n_fail++; $display("FAIL stall_resume: rom_req got %b want 1", rom_req);
    end

    // A non-M destination ignores mem_busy and goes straight back to FETCH.
    issue(16'hE310, 1'b0);
    cyc();
    rom_ack = 1'b0;
    mem_busy = 1'b1;
    #1;
    ew = exp_instr_q.pop_front();
    ej = exp_jump_q.pop_front();
    n_checks++;
    if ({instr_valid, instr, pc_load, pc_inc} !== {1'b1, ew, ej, ~ej}) begin
      n_fail++;
      $display("FAIL nostall_exec: valid/instr/load/inc got %b/%h/%b/%b want 1/%h/%b/%b",
               instr_valid, instr, pc_load, pc_inc, ew, ej, ~ej);
    end
    cyc();
    mem_busy = 1'b0;
    n_checks++;
    if (rom_req !== 1'b1) begin
      n_fail++; $display("FAIL nostall_fetch: rom_req got %b want 1", rom_req);
    end

    // Stall that ends with halt_req high lands in HALT.
    issue(16'hE308, 1'b0);
    cyc();
    rom_ack = 1'b0;
    mem_busy = 1'b1;
    halt_req = 1'b1;
    ew = exp_instr_q.pop_front();
    ej = exp_jump_q.pop_front();
    cyc();
    mem_busy = 1'b0;
    cyc();
    n_checks++;
    if ({halted, rom_req} !== 2'b10) begin
      n_fail++; $display("FAIL stall_to_halt: halted/req got %b want 10", {halted, rom_req});
    end
    halt_req = 1'b0;
    cyc();
    n_checks++;
    if ({halted, rom_req} !== 2'b01) begin
      n_fail++; $display("FAIL stall_halt_resume: halted/req got %b want 01", {halted, rom_req});
    end
  endtask

  task automatic test_halt();
    logic [15:0] ew;
    logic        ej;
    bit          ok;
    wait_fetch(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL halt_fetch_timeout: rom_req got %b want 1", rom_req);
    end
    rom_ack = 1'b0;
    halt_req = 1'b1;
    cyc();
    n_checks++;
    if ({rom_req, halted} !== 2'b10) begin
      n_fail++; $display("FAIL halt_midfetch: req/halted got %b want 10", {rom_req, halted});
    end
    issue(16'h0003, 1'b0);
    cyc();
    rom_ack = 1'b0;
    ew = exp_instr_q.pop_front();
    ej = exp_jump_q.pop_front();
    n_checks++;
    if ({instr_valid, instr, pc_load, pc_inc} !== {1'b1, ew, ej, ~ej}) begin
      n_fail++;
      $display("FAIL halt_exec: valid/instr/load/inc got %b/%h/%b/%b want 1/%h/%b/%b",
               instr_valid, instr, pc_load, pc_inc, ew, ej, ~ej);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_checks++;
      if ({halted, rom_req, instr_valid, pc_load, pc_inc} !== 5'b10000) begin
        n_fail++;
        $display("FAIL halt_hold%0d: halted/req/valid/load/inc got %b want 10000",
                 i, {halted, rom_req, instr_valid, pc_load, pc_inc});
      end
    end
    halt_req = 1'b0;
    cyc();
    n_checks++;
    if ({halted, rom_req} !== 2'b01) begin
      n_fail++; $display("FAIL halt_resume: halted/req got %b want 01", {halted, rom_req});
    end
  endtask

  task automatic test_async_reset_and_wrap();
    logic [15:0] ew;
    logic        ej;
    bit          ok;
    wait_fetch(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL areset_fetch_timeout: rom_req got %b want 1", rom_req);
    end
    rom_ack = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({rom_req, instr_valid, pc_load, pc_inc, halted} !== 5'b0) begin
      n_fail++;
      $display("FAIL areset_strobes: req/valid/load/inc/halted got %b want 00000",
               {rom_req, instr_valid, pc_load, pc_inc, halted});
    end
    n_checks++;
    if ({instr, instr_count} !== 32'h0) begin
      n_fail++; $display("FAIL areset_regs: instr/count got %h/%h want 0000/0000", instr, instr_count);
    end
    rom_ack = 1'b1;
    rom_data = 16'hBEEF;
    cyc();
    n_checks++;
    if ({rom_req, instr} !== {1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL areset_late_ack: req/instr got %b/%h want 0/0000", rom_req, instr);
    end
    reset = 1'b0;
    rom_ack = 1'b0;
    cyc();
    wait_fetch(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL wrap_fetch_timeout: rom_req got %b want 1", rom_req);
    end
    force dut.instr_count = 16'hFFFF;
    #1;
    release dut.instr_count;
    issue(16'hEA87, 1'b1);
    cyc();
    rom_ack = 1'b0;
    ew = exp_instr_q.pop_front();
    ej = exp_jump_q.pop_front();
    n_checks++;
    if ({instr_valid, instr, pc_load, pc_inc} !== {1'b1, ew, ej, ~ej}) begin
      n_fail++;
      $display("FAIL wrap_exec: valid/instr/load/inc got %b/%h/%b/%b want 1/%h/%b/%b",
               instr_valid, instr, pc_load, pc_inc, ew, ej, ~ej);
    end
    cyc();
    n_checks++;
    if (instr_count !== 16'h0000) begin
      n_fail++; $display("FAIL count_wrap: got %h want 0000", instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_jump_decode();
    test_rom_latency();
    test_mem_stall();
    test_halt();
    test_async_reset_and_wrap();
    n_checks++;
    if (exp_instr_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left want 0", exp_instr_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_sequencer.md
# hack_sequencer

Multi-cycle fetch/execute sequencer for the Hack CPU.
- Fetches each instruction from instruction ROM over a req/ack handshake and holds it in an instruction register.
- Evaluates the Hack jump condition from the ALU flags and pulses the program counter's load or increment control once per instruction.
- Stalls on data-memory writes and supports an external halt.
- Sits between the instruction ROM, the CPU datapath (ALU flags, A register) and the program counter. The jump target comes from the datapath's A register, not from this block.

## Interface
Parameters: none.
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- rom_req  out  1  instruction fetch request
- rom_ack  in  1  ROM has valid data on rom_data this cycle
- rom_data  in  16  instruction word from ROM
- instr  out  16  instruction register
- instr_valid  out  1  instr is being executed this cycle (one pulse per instruction)
- zr  in  1  ALU output == 0 for instr, valid while instr_valid
- ng  in  1  ALU output < 0 for instr, valid while instr_valid
- mem_busy  in  1  data memory cannot complete a write this cycle
- pc_load  out  1  PC loads A register at next edge
- pc_inc  out  1  PC increments at next edge
- halt_req  in  1  request to stop after the current instruction
- halted  out  1  sequencer is in HALT
- instr_count  out  16  number of retired instructions

## Operation
- States: IDLE, FETCH, EXEC, WAIT_MEM, HALT. Encoding is free.
- IDLE: entered on reset; all strobes low. Goes to FETCH unconditionally at the next edge.
- FETCH:
  - rom_req=1.
  - On an edge with rom_ack=1: instr <= rom_data, go to EXEC.
  - Otherwise stay in FETCH with rom_req held high.
- EXEC (exactly one cycle): instr_valid=1.
  - Jump decode:
    - C-instruction when instr[15]=1.
    - jump = instr[15] & ((instr[2] & ng) | (instr[1] & zr) | (instr[0] & ~ng & ~zr)).
    - A-instructions never jump.
  - Strobes: pc_load=jump and pc_inc=~jump, so exactly one is high. They are combinational from state, instr, zr and ng.
  - instr_count <= instr_count+1, 16-bit wrap (0xFFFF -> 0x0000).
  - Next state, in priority order:
    1. mem write stall: instr[15] & instr[3] & mem_busy -> WAIT_MEM.
    2. halt_req -> HALT.
    3. Otherwise -> FETCH.
- WAIT_MEM:
  - All strobes low; the PC update has already happened in EXEC.
  - Leaves when mem_busy=0: to HALT if halt_req=1, else to FETCH.
- HALT:
  - halted=1, rom_req=0, strobes low.
  - Goes to FETCH at the first edge with halt_req=0.
- halt_req is sampled only in EXEC and WAIT_MEM, never mid-fetch. A fetch in progress always completes and executes.
- instr holds its value in every state except the FETCH completion edge.

## Timing
- Reset, asynchronous: state=IDLE, instr=0x0000, instr_count=0. rom_req, instr_valid, pc_load, pc_inc and halted all go low immediately, without waiting for clk.
- Reset asserted mid-FETCH drops rom_req at once. Any late rom_ack is ignored.
- After reset deassertion: IDLE for 1 cycle, then rom_req=1 from the 2nd edge.
- Best-case throughput, with rom_ack high in the first FETCH cycle and no stall: 2 cycles per instruction (FETCH, EXEC).
- Each cycle of rom_ack delay adds 1 cycle. Each cycle of mem_busy in WAIT_MEM adds 1 cycle.
- pc_load and pc_inc are only ever high in EXEC; they are never high simultaneously.
- zr and ng are sampled only in EXEC; their values in other states are don't-care.
- rom_ack outside FETCH is ignored.
- mem_busy is ignored in EXEC when the instruction does not write M.

## Test plan
1. Reset, then program 0x0005, 0xEC10 with rom_ack tied high. Expect:
   - rom_req from cycle 2.
   - instr_valid on alternating cycles.
   - pc_inc=1, pc_load=0 in both EXECs.
   - instr_count=2 after the second EXEC.
2. Jump decode: instr=0xE307 (JMP) with any flags -> pc_load=1. instr=0xE302 (JEQ):
   - zr=1 -> pc_load=1.
   - zr=0 -> pc_inc=1.
   - Check 0xE301 (JGT) with ng=0, zr=0 -> pc_load=1.
   - Check 0x0007 (A-instruction) -> pc_inc=1.
3. ROM latency: rom_ack delayed 3 cycles. Expect rom_req held 4 cycles, instr latched only on the ack edge, then a single EXEC.
4. Memory stall: instr=0xE308 (M=…) with mem_busy=1 for 2 cycles.
   - pc_inc pulses once, in EXEC.
   - 2 cycles in WAIT_MEM with no strobes.
   - FETCH resumes the cycle after mem_busy=0.
5. Halt:
   - halt_req raised during FETCH: the instruction still executes, then halted=1 with rom_req=0.
   - Dropping halt_req resumes FETCH at the next edge.
6. Async reset asserted mid-FETCH, between edges: rom_req and strobes drop immediately. Also preload instr_count=0xFFFF, execute one instruction, and check it wraps to 0x0000.
